t04_mem_handler: RTL and testbench

- Bus-side neighbour of the core datapath: consumes the datapath's memory requests (`final_address`, `mem_store`, `MemRead_O`, `MemWrite_O`) plus a fetch request.
- Runs one Wishbone-style single-beat transaction at a time and returns `i_ack`/`d_ack` with `instruction`/`memload` to the datapath.
- Adds request latching, fixed priority, a bus timeout and a sticky error flag.
- Sits between the core and the SoC bus/SRAM arbiter.

---
 rtl/t04_mem_pkg.sv | 32 +++
 rtl/t04_mem_handler.sv | 114 +++++++++++
 tb/tb_t04_mem_handler.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/t04_mem_pkg.sv
// Shared types and constants for the core-side Wishbone memory handler.
package t04_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } mem_state_t;

  typedef enum logic [1:0] {
    K_FETCH = 2'd0,
    K_LOAD  = 2'd1,
    K_STORE = 2'd2
  } req_kind_t;

  typedef struct packed {
    req_kind_t   kind;
    logic [31:0] adr;
    logic [31:0] dat;
  } mem_req_t;

  localparam logic [3:0]  WB_SEL_FULL  = 4'hF;
  localparam logic [31:0] ERR_DATA_DEF = 32'h0000_0013;

  // Fixed priority: store beats load beats fetch.
  function automatic req_kind_t pick_kind(input logic wr, input logic rd);
    if (wr)      return K_STORE;
    else if (rd) return K_LOAD;
    else         return K_FETCH;
  endfunction

endpackage

// File: rtl/t04_mem_handler.sv
// Single-outstanding Wishbone master serving core fetch/load/store requests,
// with a bus timeout that returns ERR_DATA and raises a sticky error flag.
module t04_mem_handler
  import t04_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_DATA       = ERR_DATA_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_req,
  input  logic        MemRead_O,
  input  logic        MemWrite_O,
  input  logic [31:0] final_address,
  input  logic [31:0] mem_store,
  output logic [31:0] instruction,
  output logic [31:0] memload,
  output logic        i_ack,
  output logic        d_ack,
  output logic        bus_err,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        err_clr
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  mem_state_t  state_q, state_d;
  mem_req_t    req_q, req_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] load_q, load_d;
  logic        err_q, err_d;
  logic        any_req;
  logic        timeout;

  assign any_req = fetch_req | MemRead_O | MemWrite_O;
  // An ack on the last allowed cycle still wins over the timeout.
  assign timeout = (state_q == BUS) && !wb_ack_i && (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    cnt_d   = cnt_q;
    instr_d = instr_q;
    load_d  = load_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          req_d.kind = pick_kind(MemWrite_O, MemRead_O);
          req_d.adr  = final_address & ~32'd3;
          req_d.dat  = mem_store;
          cnt_d      = '0;
          state_d    = BUS;
        end
      end
      BUS: begin
        cnt_d = cnt_q + 1'b1;
        if (wb_ack_i) begin
          state_d = RESP;
          if (req_q.kind == K_FETCH)     instr_d = wb_dat_i;
          else if (req_q.kind == K_LOAD) load_d  = wb_dat_i;
        end else if (timeout) begin
          state_d = RESP;
          if (req_q.kind == K_FETCH)     instr_d = ERR_DATA;
          else if (req_q.kind == K_LOAD) load_d  = ERR_DATA;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Setting on the same cycle as a clear leaves the flag set.
  assign err_d = timeout | (err_q & ~err_clr);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      req_q   <= '{kind: K_FETCH, adr: '0, dat: '0};
      cnt_q   <= '0;
      instr_q <= ERR_DATA;
      load_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      cnt_q   <= cnt_d;
      instr_q <= instr_d;
      load_q  <= load_d;
      err_q   <= err_d;
    end
  end

  assign wb_cyc_o    = (state_q == BUS);
  assign wb_stb_o    = (state_q == BUS);
  assign wb_we_o     = (state_q == BUS) && (req_q.kind == K_STORE);
  assign wb_sel_o    = (state_q == BUS) ? WB_SEL_FULL : 4'h0;
  assign wb_adr_o    = req_q.adr;
  assign wb_dat_o    = req_q.dat;
  assign i_ack       = (state_q == RESP) && (req_q.kind == K_FETCH);
  assign d_ack       = (state_q == RESP) && (req_q.kind != K_FETCH);
  assign instruction = instr_q;
  assign memload     = load_q;
  assign bus_err     = err_q;

endmodule

// File: tb/tb_t04_mem_handler.sv
// Scoreboard bench: requester driver, Wishbone slave responder with its own
// memory, and an ack monitor compared against a queue-based reference model.
module tb_t04_mem_handler;

  localparam int          TO  = 255;
  localparam logic [31:0] ERR = 32'h0000_0013;

  logic        clk, rst;
  logic        fetch_req, MemRead_O, MemWrite_O, err_clr;
  logic [31:0] final_address, mem_store;
  logic [31:0] instruction, memload;
  logic        i_ack, d_ack, bus_err;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
  logic [3:0]  wb_sel_o;
  logic        wb_ack_i;

  t04_mem_handler dut (
    .clk(clk), .rst(rst), .fetch_req(fetch_req), .MemRead_O(MemRead_O),
    .MemWrite_O(MemWrite_O), .final_address(final_address), .mem_store(mem_store),
    .instruction(instruction), .memload(memload), .i_ack(i_ack), .d_ack(d_ack),
    .bus_err(bus_err), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .err_clr(err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // kind: 0 fetch, 1 load, 2 store
  typedef struct { int kind; logic [31:0] d; logic e; } resp_t;
  typedef struct { logic we; logic [31:0] adr; logic [31:0] dat; } bus_t;

  resp_t er[$];
  bus_t  eb[$];
  int    wq[$];

  logic [31:0] rmem [logic [31:0]];
  logic [31:0] bmem [logic [31:0]];
  logic [31:0] instr_m, load_m;
  logic        err_m;
  int tests = 0, fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] pat(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1234_5678;
  endfunction

  function automatic logic [31:0] rd_ref(input logic [31:0] a);
    return rmem.exists(a) ? rmem[a] : pat(a);
  endfunction

  task automatic push_expect(input int kind, input logic [31:0] a, input logic [31:0] d, input int w);
    logic [31:0] al, ed;
    logic to;
    al = a & ~32'd3;
    to = (w >= TO);
    eb.push_back('{kind == 2, al, d});
    wq.push_back(w);
    if (to) err_m = 1'b1;
    ed = '0;
    case (kind)
      0: begin ed = to ? ERR : rd_ref(al); instr_m = ed; end
      1: begin ed = to ? ERR : rd_ref(al); load_m = ed; end
      default: begin if (!to) rmem[al] = d; ed = load_m; end
    endcase
    er.push_back('{kind, ed, err_m});
  endtask

  // Issue at a negedge with the DUT idle; services every raised flag in priority order.
  task automatic issue(input bit wr, input bit rd, input bit fe,
                       input logic [31:0] a, input logic [31:0] d,
                       input int w0, input int w1, input int w2, input int clr_at);
    int idx, base, w, n, kind, exp_n;
    bit got;
    MemWrite_O = wr; MemRead_O = rd; fetch_req = fe;
    final_address = a; mem_store = d;
    idx = 0; base = 1;
    while (MemWrite_O || MemRead_O || fetch_req) begin
      kind = MemWrite_O ? 2 : (MemRead_O ? 1 : 0);
      w = (idx == 0) ? w0 : ((idx == 1) ? w1 : w2);
      push_expect(kind, final_address, mem_store, w);
      n = 0; got = 0;
      while (!got && n < 400) begin
        @(negedge clk);
        n++;
        err_clr = (idx == 0 && n == clr_at);
        if (i_ack || d_ack) got = 1;
        else if (wb_cyc_o) begin
          final_address = $urandom; mem_store = $urandom;
        end
      end
      err_clr = 1'b0;
      if (!got) begin
        tests++; fails++;
        $display("FAIL ack_wait: no ack within %0d cycles (kind %0d)", n, kind);
        MemWrite_O = 0; MemRead_O = 0; fetch_req = 0;
        er.delete(); eb.delete(); wq.delete();
      end else begin
        exp_n = ((w >= TO) ? TO : w + 1) + base;
        chk("ack_latency", n, exp_n);
        if (kind == 2) MemWrite_O = 0;
        else if (kind == 1) MemRead_O = 0;
        else fetch_req = 0;
        final_address = 32'h1000 + $urandom_range(0, 63);
        mem_store = $urandom;
      end
      idx++; base = 2;
    end
    @(negedge clk);
  endtask

  // Wishbone slave: checks bus fields every BUS cycle, acks after the queued wait.
  initial begin : responder
    bit active, have;
    int k, cur_w;
    bus_t cur;
    active = 0; have = 0; k = 0; cur_w = 0;
    cur = '{1'b0, 32'h0, 32'h0};
    wb_ack_i = 1'b0; wb_dat_i = '0;
    forever begin
      @(negedge clk);
      if (wb_cyc_o) begin
        if (!active) begin
          active = 1; k = 0;
          have = (wq.size() != 0) && (eb.size() != 0);
          if (!have) begin
            tests++; fails++;
            $display("FAIL bus_unexpected: cycle at adr %h with nothing queued", wb_adr_o);
            cur_w = 100000;
          end else begin
            cur_w = wq.pop_front();
            cur = eb.pop_front();
          end
        end
        k++;
        if (have) begin
          chk("wb_adr", wb_adr_o, cur.adr);
          chk("wb_we", wb_we_o, cur.we);
          chk("wb_sel", wb_sel_o, 4'hF);
          chk("wb_stb", wb_stb_o, 1'b1);
          if (cur.we) chk("wb_dat", wb_dat_o, cur.dat);
        end
        if (k == cur_w + 1) begin
          wb_ack_i = 1'b1;
          if (wb_we_o) begin bmem[wb_adr_o] = wb_dat_o; wb_dat_i = $urandom; end
          else wb_dat_i = bmem.exists(wb_adr_o) ? bmem[wb_adr_o] : pat(wb_adr_o);
        end else begin
          wb_ack_i = 1'b0; wb_dat_i = $urandom;
        end
      end else begin
        active = 0;
        wb_ack_i = ($urandom_range(0, 3) == 0);
        wb_dat_i = $urandom;
      end
    end
  end

  initial begin : monitor
    resp_t e;
    forever begin
      @(negedge clk);
      if (i_ack || d_ack) begin
        if (i_ack && d_ack) begin
          tests++; fails++;
          $display("FAIL ack_both: i_ack and d_ack together");
        end
        if (er.size() == 0) begin
          tests++; fails++;
          $display("FAIL ack_spurious: i_ack=%b d_ack=%b with nothing pending", i_ack, d_ack);
        end else begin
          e = er.pop_front();
          chk("ack_kind_i", i_ack, e.kind == 0);
          if (e.kind == 0) chk("instruction", instruction, e.d);
          else chk("memload", memload, e.d);
          chk("bus_err", bus_err, e.e);
        end
      end
    end
  end

  task automatic chk_reset_state();
    chk("rst_cyc", wb_cyc_o, 1'b0);
    chk("rst_stb", wb_stb_o, 1'b0);
    chk("rst_we", wb_we_o, 1'b0);
    chk("rst_sel", wb_sel_o, 4'h0);
    chk("rst_iack", i_ack, 1'b0);
    chk("rst_dack", d_ack, 1'b0);
    chk("rst_err", bus_err, 1'b0);
    chk("rst_instr", instruction, ERR);
    chk("rst_memload", memload, 32'h0);
    instr_m = ERR; load_m = '0; err_m = 1'b0;
  endtask

  initial begin : driver
    bit wr, rd, fe;
    int w0, w1, w2;
    rst = 1'b0; err_clr = 1'b0;
    fetch_req = 0; MemRead_O = 0; MemWrite_O = 0;
    final_address = '0; mem_store = '0;
    instr_m = ERR; load_m = '0; err_m = 1'b0;
    rmem[32'h100] = 32'h00A00093;
    bmem[32'h100] = 32'h00A00093;
    repeat (3) @(negedge clk);
    chk_reset_state();
    chk("rst_adr", wb_adr_o, 32'h0);
    rst = 1'b1;
    @(negedge clk);

    issue(0, 0, 1, 32'h0000_0102, 32'h0, 0, 0, 0, -1);
    issue(1, 0, 0, 32'h0000_2000, 32'hDEADBEEF, 3, 0, 0, -1);
    issue(0, 1, 1, 32'h0000_2000, 32'h0, 1, 0, 0, -1);
    issue(0, 1, 0, 32'h0000_3000, 32'h0, 300, 0, 0, -1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0; err_m = 1'b0;
    chk("err_clear", bus_err, 1'b0);
    issue(0, 1, 0, 32'h0000_2001, 32'h0, TO - 1, 0, 0, -1);
    issue(1, 0, 0, 32'h0000_3004, 32'h1111_2222, 300, 0, 0, -1);
    issue(0, 0, 1, 32'h0000_3008, 32'h0, 300, 0, 0, TO);

    // Abort mid-BUS: no ack, everything back to reset values.
    MemRead_O = 1; final_address = 32'h0000_4000;
    eb.push_back('{1'b0, 32'h0000_4000, 32'h0});
    wq.push_back(100000);
    @(negedge clk);
    MemRead_O = 0;
    repeat (2) @(negedge clk);
    chk("abort_cyc_pre", wb_cyc_o, 1'b1);
    rst = 1'b0;
    @(negedge clk);
    chk_reset_state();
    rst = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 60; i++) begin
      {wr, rd, fe} = 3'($urandom_range(1, 7));
      w0 = ($urandom_range(0, 29) == 0) ? 300 : $urandom_range(0, 4);
      w1 = $urandom_range(0, 4);
      w2 = $urandom_range(0, 4);
      issue(wr, rd, fe, 32'h1000 + $urandom_range(0, 63), $urandom, w0, w1, w2, -1);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end

    repeat (4) @(negedge clk);
    chk("queues_drained", er.size() + eb.size() + wq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
